regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/regfile_sb_if.sv | 46 ++++
 rtl/regfile_sb_scoreboard.sv | 66 ++++++
 rtl/regfile_sb.sv | 85 ++++++++
 tb/tb_regfile_sb.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared register-file constants and the read-port bypass
//               select function.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_XLEN_DEF = 32;
    localparam int c_NREG_DEF = 32;
    localparam int c_X0_ADDR  = 0;

    typedef enum logic [1:0] {
        SRC_REG = 2'd0,
        SRC_WA  = 2'd1,
        SRC_WB  = 2'd2
    } rd_src_e;

    // Port B is checked first so a dual write to one address forwards wb_data.
    function automatic rd_src_e bypass_sel(input logic bypass,
                                           input logic hit_wa,
                                           input logic hit_wb);
        if (!bypass) return SRC_REG;
        if (hit_wb)  return SRC_WB;
        if (hit_wa)  return SRC_WA;
        return SRC_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_if
// Description : Read, writeback and load-tracking bus of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if import cpu_pkg::*; #(
    parameter int XLEN = c_XLEN_DEF,
    parameter int NREG = c_NREG_DEF
);
    localparam int AW = $clog2(NREG);

    logic            rs1_en;
    logic            rs2_en;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wa_en;
    logic [AW-1:0]   wa_addr;
    logic [XLEN-1:0] wa_data;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            ld_issue;
    logic [AW-1:0]   ld_rd;
    logic            stall;
    logic [AW:0]     pend_cnt;
    logic            err_waw;

    modport master (
        output rs1_en, rs2_en, rs1_addr, rs2_addr,
        output wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
        output ld_issue, ld_rd,
        input  rs1_data, rs2_data, stall, pend_cnt, err_waw
    );

    modport slave (
        input  rs1_en, rs2_en, rs1_addr, rs2_addr,
        input  wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
        input  ld_issue, ld_rd,
        output rs1_data, rs2_data, stall, pend_cnt, err_waw
    );

endinterface
`default_nettype wire

// File: rtl/regfile_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register load-pending bits, their population count and
//               the sticky write-after-write hazard flag.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard import cpu_pkg::*; #(
    parameter int NREG = c_NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_ld_issue,
    input  wire logic [AW-1:0]   i_ld_rd,
    input  wire logic            i_wb_en,
    input  wire logic [AW-1:0]   i_wb_addr,
    input  wire logic            i_wa_en,
    input  wire logic [AW-1:0]   i_wa_addr,
    output logic      [NREG-1:0] o_busy,
    output logic      [AW:0]     o_pend_cnt,
    output logic                 o_err_waw
);
    localparam logic [AW-1:0] c_X0 = AW'(c_X0_ADDR);

    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_pend_cnt;
    logic            r_err_waw;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     w_pend_nxt;

    // Set is applied after clear so a load issued alongside its own return stays pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wb_en)    w_busy_nxt[i_wb_addr] = 1'b0;
        if (i_ld_issue) w_busy_nxt[i_ld_rd]   = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            w_pend_nxt = w_pend_nxt + (AW+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
            r_err_waw  <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= w_pend_nxt;
            if (i_wa_en && (i_wa_addr != c_X0) && r_busy[i_wa_addr]) begin
                r_err_waw <= 1'b1;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_pend_cnt = r_pend_cnt;
    assign o_err_waw  = r_err_waw;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Two-read, two-write register file with optional same-cycle
//               write forwarding and a load scoreboard driving stall.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb import cpu_pkg::*; #(
    parameter int XLEN   = c_XLEN_DEF,
    parameter int NREG   = c_NREG_DEF,
    parameter int BYPASS = 1
) (
    input wire logic  clk,
    input wire logic  rst,
    regfile_sb_if.slave bus
);
    localparam int            AW   = $clog2(NREG);
    localparam logic [AW-1:0] c_X0 = AW'(c_X0_ADDR);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] w_busy;
    logic            w_rd_en    [2];
    logic [AW-1:0]   w_rd_addr  [2];
    logic [XLEN-1:0] w_rd_data  [2];
    logic            w_rd_stall [2];

    // Port B is written last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            if (bus.wa_en && (bus.wa_addr != c_X0)) r_regs[bus.wa_addr] <= bus.wa_data;
            if (bus.wb_en && (bus.wb_addr != c_X0)) r_regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    assign w_rd_en[0]   = bus.rs1_en;
    assign w_rd_en[1]   = bus.rs2_en;
    assign w_rd_addr[0] = bus.rs1_addr;
    assign w_rd_addr[1] = bus.rs2_addr;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic    w_live;
        logic    w_hit_wa;
        logic    w_hit_wb;
        rd_src_e w_src;

        assign w_live   = rst && w_rd_en[p] && (w_rd_addr[p] != c_X0);
        assign w_hit_wa = bus.wa_en && (bus.wa_addr == w_rd_addr[p]);
        assign w_hit_wb = bus.wb_en && (bus.wb_addr == w_rd_addr[p]);
        assign w_src    = bypass_sel(BYPASS != 0, w_hit_wa, w_hit_wb);

        assign w_rd_data[p] = !w_live           ? '0          :
                              (w_src == SRC_WB) ? bus.wb_data :
                              (w_src == SRC_WA) ? bus.wa_data :
                                                  r_regs[w_rd_addr[p]];

        // A returning load to the same register is already forwarded, so it does not stall.
        assign w_rd_stall[p] = w_live && w_busy[w_rd_addr[p]] &&
                               !((BYPASS != 0) && w_hit_wb);
    end

    reg_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_ld_issue (bus.ld_issue),
        .i_ld_rd    (bus.ld_rd),
        .i_wb_en    (bus.wb_en),
        .i_wb_addr  (bus.wb_addr),
        .i_wa_en    (bus.wa_en),
        .i_wa_addr  (bus.wa_addr),
        .o_busy     (w_busy),
        .o_pend_cnt (bus.pend_cnt),
        .o_err_waw  (bus.err_waw)
    );

    assign bus.rs1_data = w_rd_data[0];
    assign bus.rs2_data = w_rd_data[1];
    assign bus.stall    = w_rd_stall[0] | w_rd_stall[1];

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Directed scoreboard bench; a BYPASS=1 and a BYPASS=0 instance
//               share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        rs1_en, rs2_en, wa_en, wb_en, ld_issue;
    logic [4:0]  rs1_addr, rs2_addr, wa_addr, wb_addr, ld_rd;
    logic [31:0] wa_data, wb_data;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [31:0] rs1;
        logic [31:0] rs1_nb;
        logic [31:0] rs2;
        logic        stall;
        logic        stall_nb;
        logic [5:0]  pend;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    regfile_sb_if #(.XLEN(32), .NREG(32)) bus_b ();
    regfile_sb_if #(.XLEN(32), .NREG(32)) bus_n ();

    assign bus_b.rs1_en = rs1_en;     assign bus_n.rs1_en = rs1_en;
    assign bus_b.rs2_en = rs2_en;     assign bus_n.rs2_en = rs2_en;
    assign bus_b.rs1_addr = rs1_addr; assign bus_n.rs1_addr = rs1_addr;
    assign bus_b.rs2_addr = rs2_addr; assign bus_n.rs2_addr = rs2_addr;
    assign bus_b.wa_en = wa_en;       assign bus_n.wa_en = wa_en;
    assign bus_b.wa_addr = wa_addr;   assign bus_n.wa_addr = wa_addr;
    assign bus_b.wa_data = wa_data;   assign bus_n.wa_data = wa_data;
    assign bus_b.wb_en = wb_en;       assign bus_n.wb_en = wb_en;
    assign bus_b.wb_addr = wb_addr;   assign bus_n.wb_addr = wb_addr;
    assign bus_b.wb_data = wb_data;   assign bus_n.wb_data = wb_data;
    assign bus_b.ld_issue = ld_issue; assign bus_n.ld_issue = ld_issue;
    assign bus_b.ld_rd = ld_rd;       assign bus_n.ld_rd = ld_rd;

    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) u_dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s.%s: got %h expected %h", tag, fld, got, want);
        end
    endtask

    // Monitor: outputs are combinational, so each pending expectation is checked mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.name, "rs1",      bus_b.rs1_data,          e.rs1);
            chk(e.name, "rs2",      bus_b.rs2_data,          e.rs2);
            chk(e.name, "stall",    32'(bus_b.stall),        32'(e.stall));
            chk(e.name, "pend",     32'(bus_b.pend_cnt),     32'(e.pend));
            chk(e.name, "err",      32'(bus_b.err_waw),      32'(e.err));
            chk(e.name, "rs1_nb",   bus_n.rs1_data,          e.rs1_nb);
            chk(e.name, "stall_nb", 32'(bus_n.stall),        32'(e.stall_nb));
            chk(e.name, "pend_nb",  32'(bus_n.pend_cnt),     32'(e.pend));
        end
    end

    task automatic push_exp(input string name, input logic [31:0] rs1, input logic [31:0] rs1_nb,
                            input logic [31:0] rs2, input logic stall, input logic stall_nb,
                            input logic [5:0] pend, input logic err);
        exp_t e;
        e.name = name; e.rs1 = rs1; e.rs1_nb = rs1_nb; e.rs2 = rs2;
        e.stall = stall; e.stall_nb = stall_nb; e.pend = pend; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        rs1_en = 0; rs2_en = 0; wa_en = 0; wb_en = 0; ld_issue = 0;
        rs1_addr = 0; rs2_addr = 0; wa_addr = 0; wb_addr = 0; ld_rd = 0;
        wa_data = 0; wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        idle();
        // Writes and loads presented during reset must have no effect
        rs1_en = 1; rs1_addr = 3;
        wa_en = 1; wa_addr = 3; wa_data = 32'hAAAA_AAAA;
        wb_en = 1; wb_addr = 3; wb_data = 32'hBBBB_BBBB;
        ld_issue = 1; ld_rd = 6;
        push_exp("in_reset", 0, 0, 0, 0, 0, 0, 0);
        tick();

        idle(); rst = 1'b1;
        rs1_en = 1; rs1_addr = 5; rs2_en = 1; rs2_addr = 3;
        push_exp("x5_after_reset", 0, 0, 0, 0, 0, 0, 0);

        tick(); idle();
        wa_en = 1; wa_addr = 3; wa_data = 32'hDEADBEEF; rs1_en = 1; rs1_addr = 3;
        push_exp("bypass_x3", 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);

        tick(); idle(); rs1_en = 1; rs1_addr = 3;
        push_exp("read_x3", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0, 0);

        tick(); idle();
        wa_en = 1; wa_addr = 7; wa_data = 32'h11; wb_en = 1; wb_addr = 7; wb_data = 32'h22;
        rs1_en = 1; rs1_addr = 7; rs2_en = 1; rs2_addr = 3;
        push_exp("dual_wr_x7", 32'h22, 0, 32'hDEADBEEF, 0, 0, 0, 0);

        tick(); idle(); rs1_en = 1; rs1_addr = 7;
        push_exp("read_x7", 32'h22, 32'h22, 0, 0, 0, 0, 0);

        tick(); idle();
        wa_en = 1; wa_addr = 10; wa_data = 32'h1010; wb_en = 1; wb_addr = 11; wb_data = 32'h1111;
        rs1_en = 1; rs1_addr = 10; rs2_en = 1; rs2_addr = 11;
        push_exp("split_wr", 32'h1010, 0, 32'h1111, 0, 0, 0, 0);

        tick(); idle(); rs1_en = 1; rs1_addr = 10; rs2_en = 1; rs2_addr = 11;
        push_exp("read_split", 32'h1010, 32'h1010, 32'h1111, 0, 0, 0, 0);

        tick(); idle(); ld_issue = 1; ld_rd = 9; rs1_en = 1; rs1_addr = 9;
        push_exp("ld_x9_issue", 0, 0, 0, 0, 0, 0, 0);

        tick(); idle(); rs1_en = 1; rs1_addr = 9;
        push_exp("x9_busy", 0, 0, 0, 1, 1, 1, 0);

        tick(); idle(); wb_en = 1; wb_addr = 9; wb_data = 32'h55; rs1_en = 1; rs1_addr = 9;
        push_exp("x9_return", 32'h55, 0, 0, 0, 1, 1, 0);

        tick(); idle(); rs1_en = 1; rs1_addr = 9;
        push_exp("x9_done", 32'h55, 32'h55, 0, 0, 0, 0, 0);

        tick(); idle();
        ld_issue = 1; ld_rd = 12; wb_en = 1; wb_addr = 12; wb_data = 32'h77; rs1_en = 1; rs1_addr = 12;
        push_exp("ld_wb_same", 32'h77, 0, 0, 0, 0, 0, 0);

        tick(); idle(); rs1_en = 1; rs1_addr = 12;
        push_exp("x12_still_busy", 32'h77, 32'h77, 0, 1, 1, 1, 0);

        tick(); idle(); ld_issue = 1; ld_rd = 12; rs2_en = 1; rs2_addr = 12;
        push_exp("reissue_x12", 0, 0, 32'h77, 1, 1, 1, 0);

        tick(); idle(); rs1_addr = 12;
        push_exp("rd_disabled", 0, 0, 0, 0, 0, 1, 0);

        tick(); idle(); ld_issue = 1; ld_rd = 4;
        push_exp("ld_x4", 0, 0, 0, 0, 0, 1, 0);

        tick(); idle(); wa_en = 1; wa_addr = 4; wa_data = 32'h1; rs1_en = 1; rs1_addr = 4;
        push_exp("waw_x4", 32'h1, 0, 0, 1, 1, 2, 0);

        tick(); idle(); rs1_en = 1; rs1_addr = 4;
        push_exp("err_set", 32'h1, 32'h1, 0, 1, 1, 2, 1);

        tick(); idle();
        push_exp("err_holds", 0, 0, 0, 0, 0, 2, 1);

        tick(); idle();
        wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF; ld_issue = 1; ld_rd = 0; rs1_en = 1; rs1_addr = 0;
        push_exp("x0_write_ld", 0, 0, 0, 0, 0, 2, 1);

        tick(); idle(); rs1_en = 1; rs1_addr = 0;
        push_exp("x0_read", 0, 0, 0, 0, 0, 2, 1);

        tick(); idle(); rst = 1'b0; rs1_en = 1; rs1_addr = 4; rs2_en = 1; rs2_addr = 12;
        push_exp("rst_async", 0, 0, 0, 0, 0, 0, 0);

        tick(); idle(); rst = 1'b1; rs1_en = 1; rs1_addr = 4; rs2_en = 1; rs2_addr = 12;
        push_exp("post_rst", 0, 0, 0, 0, 0, 0, 0);

        tick(); idle(); rs1_en = 1; rs1_addr = 7;
        push_exp("post_rst_x7", 0, 0, 0, 0, 0, 0, 0);

        tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
